// File: rtl/maxnet_ctrl_pkg.sv
// maxnet_ctrl_pkg: shared FSM state enum, FP constants, fp_op encodings and a ReLU helper.
package maxnet_ctrl_pkg;
    typedef enum logic [3:0] {IDLE, LOAD, CHECK, SUM, DIFF, MUL, ACC, COMMIT, DONE} state_t;
    localparam logic [31:0] FP_ZERO     = 32'h0000_0000;
    localparam int          FP_SIGN_BIT = 31;
    localparam logic        FP_OP_MUL   = 1'b0;
    localparam logic        FP_OP_ADD   = 1'b1;
    // Negative values and both signed zeros collapse to +0.
    function automatic logic [31:0] fp_relu(input logic [31:0] x);
        return (x[FP_SIGN_BIT] || x[30:0] == 31'd0) ? FP_ZERO : x;
    endfunction
endpackage

// File: rtl/maxnet_relu_cnt.sv
// maxnet_relu_cnt: combinational ReLU, zero detect and nonzero count/index over four FP words.
module maxnet_relu_cnt
    import maxnet_ctrl_pkg::*;
(
    input  logic [127:0] i_a,
    output logic [127:0] o_relu,
    output logic [2:0]   o_cnt,
    output logic [1:0]   o_idx
);
    logic [3:0] w_nz;
    always_comb begin
        o_relu = '0;
        w_nz   = '0;
        o_cnt  = '0;
        o_idx  = '0;
        for (int k = 3; k >= 0; k--) begin
            o_relu[32*k +: 32] = fp_relu(i_a[32*k +: 32]);
            w_nz[k]            = o_relu[32*k +: 32] != FP_ZERO;
            o_cnt              = o_cnt + 3'(w_nz[k]);
            o_idx              = w_nz[k] ? 2'(k) : o_idx;
        end
    end
endmodule

// File: rtl/maxnet_ctrl.sv
// maxnet_ctrl: four-neuron MAXNET iteration controller sequencing a shared FP add/multiply unit.
// Define MAXNET_CTRL_TIMEOUT_EN to stop with timeout=1 once iter_count reaches MAX_ITER.
module maxnet_ctrl
    import maxnet_ctrl_pkg::*;
#(
    parameter int MAX_ITER = 64,
    parameter int IW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [31:0]   eps,
    input  logic [127:0]  a_in,
    output logic          fp_req,
    output logic          fp_op,
    output logic [31:0]   fp_a,
    output logic [31:0]   fp_b,
    input  logic          fp_ack,
    input  logic [31:0]   fp_res,
    input  logic          fp_ovf,
    output logic          busy,
    output logic          finish,
    output logic          overflow,
    output logic          timeout,
    output logic          winner_valid,
    output logic [1:0]    winner_idx,
    output logic [31:0]   out,
    output logic [IW-1:0] iter_count
);
    localparam logic [IW-1:0] LIMIT = IW'(MAX_ITER);

    state_t           r_state;
    logic [3:0][31:0] r_a, r_sh;
    logic [31:0]      r_s, r_o, r_fa, r_fb, r_out;
    logic [1:0]       r_i, r_k, r_idx;
    logic [IW-1:0]    r_iter;
    logic             r_req, r_op, r_busy, r_finish, r_ovf, r_wv;
    logic [127:0]     w_src, w_relu;
    logic [2:0]       w_cnt;
    logic [1:0]       w_idx;
    logic [31:0]      w_ai, w_a, w_b;
    logic             w_op;

    // LOAD rectifies the raw inputs; every other state inspects the live activations.
    assign w_src = (r_state == LOAD) ? a_in : r_a;

    maxnet_relu_cnt u_relu_cnt (
        .i_a    (w_src),
        .o_relu (w_relu),
        .o_cnt  (w_cnt),
        .o_idx  (w_idx)
    );

    always_comb begin
        w_ai = r_a[r_i];
        w_op = (r_state == MUL) ? FP_OP_MUL : FP_OP_ADD;
        w_a  = (r_state == SUM)  ? ((r_k == 2'd0) ? r_a[0] : r_s) :
               (r_state == DIFF) ? r_s :
               (r_state == MUL)  ? eps : w_ai;
        w_b  = (r_state == SUM)  ? r_a[r_k + 2'd1] :
               (r_state == DIFF) ? {~w_ai[FP_SIGN_BIT], w_ai[30:0]} : r_o;
    end

`ifdef MAXNET_CTRL_TIMEOUT_EN
    logic r_to;
    assign timeout = r_to;
`else
    logic w_unused;
    assign w_unused = ^LIMIT;
    assign timeout  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_sh     <= '0;
            r_s      <= '0;
            r_o      <= '0;
            r_fa     <= '0;
            r_fb     <= '0;
            r_out    <= '0;
            r_i      <= '0;
            r_k      <= '0;
            r_idx    <= '0;
            r_iter   <= '0;
            r_req    <= 1'b0;
            r_op     <= FP_OP_MUL;
            r_busy   <= 1'b0;
            r_finish <= 1'b0;
            r_ovf    <= 1'b0;
            r_wv     <= 1'b0;
`ifdef MAXNET_CTRL_TIMEOUT_EN
            r_to     <= 1'b0;
`endif
        end else begin
            r_finish <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_state <= LOAD;
                    r_busy  <= 1'b1;
                end
                LOAD: begin
                    r_a     <= w_relu;
                    r_iter  <= '0;
                    r_ovf   <= 1'b0;
                    r_wv    <= 1'b0;
                    r_idx   <= '0;
                    r_out   <= FP_ZERO;
`ifdef MAXNET_CTRL_TIMEOUT_EN
                    r_to    <= 1'b0;
`endif
                    r_state <= CHECK;
                end
                CHECK: begin
                    if (w_cnt <= 3'd1) begin
                        r_state  <= DONE;
                        r_finish <= 1'b1;
                        r_wv     <= w_cnt == 3'd1;
                        r_idx    <= w_idx;
                        r_out    <= (w_cnt == 3'd1) ? r_a[w_idx] : FP_ZERO;
                    end
`ifdef MAXNET_CTRL_TIMEOUT_EN
                    else if (r_iter == LIMIT) begin
                        r_state  <= DONE;
                        r_finish <= 1'b1;
                        r_to     <= 1'b1;
                    end
`endif
                    else begin
                        r_state <= SUM;
                        r_k     <= '0;
                    end
                end
                SUM, DIFF, MUL, ACC: begin
                    if (!r_req) begin
                        r_req <= 1'b1;
                        r_op  <= w_op;
                        r_fa  <= w_a;
                        r_fb  <= w_b;
                    end else if (fp_ack) begin
                        r_req <= 1'b0;
                        if (fp_ovf) begin
                            r_state  <= DONE;
                            r_finish <= 1'b1;
                            r_ovf    <= 1'b1;
                            r_wv     <= 1'b0;
                            r_idx    <= '0;
                            r_out    <= FP_ZERO;
                        end else if (r_state == SUM) begin
                            r_s <= fp_res;
                            r_k <= r_k + 2'd1;
                            if (r_k == 2'd2) begin
                                r_state <= DIFF;
                                r_i     <= '0;
                            end
                        end else if (r_state == DIFF) begin
                            r_o     <= fp_res;
                            r_state <= MUL;
                        end else if (r_state == MUL) begin
                            r_o     <= fp_res;
                            r_state <= ACC;
                        end else begin
                            r_sh[r_i] <= fp_relu(fp_res);
                            r_i       <= r_i + 2'd1;
                            r_state   <= (r_i == 2'd3) ? COMMIT : DIFF;
                        end
                    end
                end
                COMMIT: begin
                    r_a     <= r_sh;
                    r_iter  <= &r_iter ? r_iter : r_iter + 1'b1;
                    r_state <= CHECK;
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign fp_req       = r_req;
    assign fp_op        = r_op;
    assign fp_a         = r_fa;
    assign fp_b         = r_fb;
    assign busy         = r_busy;
    assign finish       = r_finish;
    assign overflow     = r_ovf;
    assign winner_valid = r_wv;
    assign winner_idx   = r_idx;
    assign out          = r_out;
    assign iter_count   = r_iter;
endmodule

// File: tb/tb_maxnet_ctrl.sv
// tb_maxnet_ctrl: randomized scoreboard bench for maxnet_ctrl with a behavioural FP unit and MAXNET model.
module tb_maxnet_ctrl;
    localparam int IW = 8;
    localparam int MAX_ITER = 64;
`ifdef MAXNET_CTRL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic [31:0] eps = '0;
    logic [127:0] a_in = '0;
    logic fp_req, fp_op, fp_ack = 1'b0, fp_ovf = 1'b0;
    logic [31:0] fp_a, fp_b, fp_res = '0;
    logic busy, finish, overflow, timeout, winner_valid;
    logic [1:0] winner_idx;
    logic [31:0] out;
    logic [IW-1:0] iter_count;

    maxnet_ctrl #(.MAX_ITER(MAX_ITER), .IW(IW)) dut (
        .clk(clk), .rst(rst), .start(start), .eps(eps), .a_in(a_in),
        .fp_req(fp_req), .fp_op(fp_op), .fp_a(fp_a), .fp_b(fp_b),
        .fp_ack(fp_ack), .fp_res(fp_res), .fp_ovf(fp_ovf),
        .busy(busy), .finish(finish), .overflow(overflow), .timeout(timeout),
        .winner_valid(winner_valid), .winner_idx(winner_idx), .out(out), .iter_count(iter_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic ovf, to, wv;
        logic [1:0] idx;
        logic [31:0] out;
        int iter, nops, ab, ib;
    } exp_t;

    exp_t sbq[$];
    int n_cmp = 0, n_bad = 0;
    int acks = 0, issues = 0;
    int hold_at = 32'h7fff_ffff;
    bit inj_ovf = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic real f2r(input logic [31:0] x);
        real m;
        int e;
        if (x[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(x[22:0]) / 8388608.0;
        e = int'(x[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return x[31] ? -m : m;
    endfunction

    // Round-to-nearest-even into single precision; subnormals flush to zero.
    function automatic logic [31:0] r2f(input real r);
        logic s;
        int e, q;
        real m, f;
        if (r == 0.0) return 32'h0;
        s = r < 0.0;
        m = s ? -r : r;
        e = 0;
        while (m >= 2.0 && e < 300) begin m = m / 2.0; e++; end
        while (m < 1.0 && e > -300) begin m = m * 2.0; e--; end
        m = m * 8388608.0;
        q = $rtoi(m);
        f = m - real'(q);
        if (f > 0.5 || (f == 0.5 && q[0])) q++;
        if (q == (1 << 24)) begin q = 1 << 23; e++; end
        if (e > 127) return {s, 8'hFF, 23'd0};
        if (e < -126) return {s, 31'd0};
        return {s, 8'(e + 127), q[22:0]};
    endfunction

    function automatic logic [31:0] fop(input bit add, input logic [31:0] x, input logic [31:0] y);
        return r2f(add ? f2r(x) + f2r(y) : f2r(x) * f2r(y));
    endfunction

    function automatic logic [31:0] relu(input logic [31:0] x);
        return (x[31] || x[30:0] == 31'd0) ? 32'h0 : x;
    endfunction

    function automatic bit op_ovf(input bit add, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] z, input bit inj, inout int n);
        z = fop(add, x, y);
        n++;
        return (inj && n == 1) || z[30:23] == 8'hFF;
    endfunction

    // MAXNET at the level of the algorithm: synchronous update of all four neurons per iteration.
    function automatic exp_t model(input logic [31:0] ai[4], input logic [31:0] e, input bit inj);
        exp_t r;
        logic [31:0] a[4], sh[4], s, t;
        int nz, w;
        r = '{default: 0};
        w = 0;
        foreach (ai[i]) a[i] = relu(ai[i]);
        while (r.iter <= 200) begin
            nz = 0;
            foreach (a[i]) if (a[i] != 32'h0) begin nz++; w = i; end
            if (nz <= 1) begin
                r.wv  = nz == 1;
                r.idx = (nz == 1) ? 2'(w) : 2'd0;
                r.out = (nz == 1) ? a[w] : 32'h0;
                return r;
            end
            if (TO_EN && r.iter == MAX_ITER) begin r.to = 1'b1; return r; end
            s = a[0];
            for (int i = 1; i < 4; i++)
                if (op_ovf(1'b1, s, a[i], s, inj, r.nops)) begin r.ovf = 1'b1; return r; end
            for (int i = 0; i < 4; i++) begin
                if (op_ovf(1'b1, s, a[i] ^ 32'h8000_0000, t, inj, r.nops)) begin r.ovf = 1'b1; return r; end
                if (op_ovf(1'b0, e, t, t, inj, r.nops)) begin r.ovf = 1'b1; return r; end
                if (op_ovf(1'b1, a[i], t, t, inj, r.nops)) begin r.ovf = 1'b1; return r; end
                sh[i] = relu(t);
            end
            a = sh;
            r.iter++;
        end
        return r;
    endfunction

    // FP unit: random 0-5 cycle latency, checks operand stability and request drop after ack.
    initial begin : responder
        bit pend, last_ack;
        int dly;
        logic [31:0] la, lb;
        logic lop;
        pend = 0; last_ack = 0; dly = 0; la = '0; lb = '0; lop = 0;
        forever begin
            @(negedge clk);
            if (last_ack && rst) chk("req_drop_after_ack", fp_req, 0);
            last_ack = 0;
            fp_ack = 1'b0;
            fp_ovf = 1'b0;
            if (!rst) begin
                fp_ack = 1'b1;
                fp_res = $urandom;
                pend = 0;
            end else if (fp_req) begin
                if (!pend) begin
                    pend = 1; dly = $urandom_range(0, 5);
                    la = fp_a; lb = fp_b; lop = fp_op;
                    issues++;
                end else begin
                    chk("stable_fp_a", fp_a, la);
                    chk("stable_fp_b", fp_b, lb);
                    chk("stable_fp_op", fp_op, lop);
                end
                if (dly > 0) dly--;
                else if (acks < hold_at) begin
                    fp_res = fop(lop, la, lb);
                    fp_ovf = inj_ovf || fp_res[30:23] == 8'hFF;
                    fp_ack = 1'b1;
                    acks++;
                    pend = 0;
                    last_ack = 1;
                end
            end
        end
    end

    initial begin : monitor
        bit prev_fin;
        exp_t e;
        prev_fin = 0;
        forever begin
            @(negedge clk);
            if (!rst) prev_fin = 0;
            else begin
                if (prev_fin) begin
                    chk("finish_one_cycle", finish, 0);
                    chk("idle_after_done", busy, 0);
                end
                prev_fin = finish;
                if (finish) begin
                    chk("busy_in_done", busy, 1);
                    if (sbq.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_finish: got finish with empty scoreboard at %0t", $time);
                    end else begin
                        e = sbq.pop_front();
                        chk("overflow", overflow, e.ovf);
                        chk("timeout", timeout, e.to);
                        chk("winner_valid", winner_valid, e.wv);
                        chk("winner_idx", winner_idx, e.idx);
                        chk("out", out, e.out);
                        chk("iter_count", iter_count, IW'(e.iter));
                        chk("fp_acks", acks - e.ab, e.nops);
                        chk("fp_requests", issues - e.ib, e.nops);
                    end
                end
            end
        end
    end

    task automatic run(input logic [31:0] a[4], input logic [31:0] e, input bit inj);
        exp_t x;
        x = model(a, e, inj);
        x.ab = acks;
        x.ib = issues;
        inj_ovf = inj;
        eps = e;
        a_in = {a[3], a[2], a[1], a[0]};
        @(negedge clk);
        start = 1'b1;
        sbq.push_back(x);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a_in = {$urandom, $urandom, $urandom, $urandom};
        for (int c = 0; c < 30000 && !finish; c++) begin
            @(negedge clk);
            start = !finish && busy && $urandom_range(0, 3) == 0;
        end
        start = 1'b0;
        if (!finish) begin
            n_cmp++; n_bad++;
            $display("FAIL run_finish: got no finish within budget, required finish at %0t", $time);
            sbq.delete();
        end
        inj_ovf = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    logic [31:0] v[4], ev;
    logic [31:0] epsl[3];
    exp_t xg;
    int k, ib0;

    initial begin
        epsl = '{32'hBE4C_CCCD, 32'hBE80_0000, 32'hBE99_999A};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_fp_req", fp_req, 0);
        chk("rst_finish", finish, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_winner_valid", winner_valid, 0);
        chk("rst_winner_idx", winner_idx, 0);
        chk("rst_out", out, 0);
        chk("rst_iter_count", iter_count, 0);
        #1 rst = 1'b1;

        v = '{32'h3F80_0000, 32'h3F00_0000, 32'h0, 32'h0};
        run(v, 32'hBE4C_CCCD, 1'b0);
        v = '{32'h0, 32'h0, 32'h40A0_0000, 32'h0};
        run(v, 32'hBE4C_CCCD, 1'b0);
        v = '{32'h3F80_0000, 32'h3F00_0000, 32'h0, 32'h0};
        run(v, 32'hBE4C_CCCD, 1'b1);
        v = '{32'h0, 32'h8000_0000, 32'hBF80_0000, 32'h0};
        run(v, 32'hBE4C_CCCD, 1'b0);
`ifdef MAXNET_CTRL_TIMEOUT_EN
        v = '{32'h461C_4000, 32'hC61C_4000, 32'h461C_4000, 32'hC61C_4000};
        run(v, 32'hBE4C_CCCD, 1'b0);
`endif

        // Stall the fifth request of the first iteration (the multiply) and reset under it.
        v = '{32'h3F80_0000, 32'h3F00_0000, 32'h0, 32'h0};
        eps = 32'hBE4C_CCCD;
        a_in = {v[3], v[2], v[1], v[0]};
        hold_at = acks + 4;
        ib0 = issues;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 500 && issues - ib0 < 5; c++) @(negedge clk);
        @(negedge clk);
        chk("mul_req_pending", fp_req, 1);
        chk("mul_op", fp_op, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_fp_req", fp_req, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_iter", iter_count, 0);
        hold_at = 32'h7fff_ffff;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        run(v, 32'hBE4C_CCCD, 1'b0);

        for (int n = 0; n < 16; n++) begin
            do begin
                foreach (v[i]) begin
                    k = $urandom_range(0, 9);
                    v[i] = (k < 2) ? 32'h0 : r2f(real'($urandom_range(1, 4000)) / 1000.0);
                    if (k == 2) v[i][31] = 1'b1;
                end
                ev = epsl[$urandom_range(0, 2)];
                xg = model(v, ev, 1'b0);
            end while (xg.iter > 25 || xg.ovf);
            run(v, ev, 1'b0);
        end

        if (sbq.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL leftover_expectations: got %0d pending, required 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
